// File: rtl/bf_pkg.sv
// Shared types for the bound flasher: lamp counter commands, sequencing phases
// and the phase-to-direction mapping used by the controller and counter generator.
package bf_pkg;

  typedef enum logic [1:0] {
    COUNT_DIS     = 2'b00,
    COUNT_UP_EN   = 2'b01,
    COUNT_DOWN_EN = 2'b10,
    COUNT_HOLD    = 2'b11
  } counter_state_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } phase_t;

  localparam int COUNTER_INIT = 0;

  function automatic counter_state_t phase_dir(input phase_t p);
    counter_state_t d;
    case (p)
      UP1, UP2, UP3: d = COUNT_UP_EN;
      DN1, DN2, DN3: d = COUNT_DOWN_EN;
      default:       d = COUNT_DIS;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bound_flasher_ctrl_if.sv
// Command bus between the flasher controller and the lamp counter generator.
interface bound_flasher_ctrl_if #(
  parameter int CNT_W = 5
);
  import bf_pkg::*;

  logic [CNT_W-1:0] counter;
  counter_state_t   counter_state;
  logic [CNT_W-1:0] counter_load;
  logic             counter_load_en;

  // Each cycle the generator applies exactly one command at the clock edge:
  // counter_load_en=1 loads counter_load and overrides counter_state; otherwise
  // counter_state selects up/down/disabled. counter is the registered result.
  modport master (
    input  counter,
    output counter_state,
    output counter_load,
    output counter_load_en
  );

  modport slave (
    output counter,
    input  counter_state,
    input  counter_load,
    input  counter_load_en
  );

endinterface

// File: rtl/bf_phase_next.sv
// Combinational next-phase decode for the bound flasher sequence.
// Kickback in DN2 is compiled in only when BF_KICKBACK_EN is defined.
module bf_phase_next
  import bf_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int MAX_VAL = 15,
  parameter int MID_HI  = 10,
  parameter int MID_LO  = 5
) (
  input  phase_t           phase,
  input  logic             flick,
  input  logic [CNT_W-1:0] counter,
  output phase_t           phase_next
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] HI_C  = CNT_W'(MID_HI);
  localparam logic [CNT_W-1:0] LO_C  = CNT_W'(MID_LO);

  // Inclusive bounds so a counter that lands outside the range still ends the phase.
  always_comb begin
    phase_next = phase;
    case (phase)
      IDLE: if (flick) phase_next = UP1;
      UP1:  if (counter >= MAX_C) phase_next = DN1;
      DN1:  if (counter <= LO_C) phase_next = UP2;
      UP2:  if (counter >= HI_C) phase_next = DN2;
      DN2: begin
        if (counter == '0) phase_next = UP3;
`ifdef BF_KICKBACK_EN
        if (flick && (counter == LO_C || counter == '0)) phase_next = UP2;
`endif
      end
      UP3:  if (counter >= LO_C) phase_next = DN3;
      DN3:  if (counter == '0) phase_next = IDLE;
      default: phase_next = IDLE;
    endcase
  end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencing controller: phase register, abort/load and done pulse.
// Define BF_KICKBACK_EN to enable flick-triggered kickback during DN2.
module bound_flasher_ctrl
  import bf_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int MAX_VAL = 15,
  parameter int MID_HI  = 10,
  parameter int MID_LO  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flick,
  input  logic                  stop,
  bound_flasher_ctrl_if.master  cnt,
  output logic                  busy,
  output logic                  done,
  output phase_t                phase
);

  phase_t phase_q;
  phase_t norm_next;
  phase_t phase_next;
  logic   stop_hit;
  logic   done_q;

  bf_phase_next #(
    .CNT_W   (CNT_W),
    .MAX_VAL (MAX_VAL),
    .MID_HI  (MID_HI),
    .MID_LO  (MID_LO)
  ) u_phase_next (
    .phase      (phase_q),
    .flick      (flick),
    .counter    (cnt.counter),
    .phase_next (norm_next)
  );

  // Direction follows the phase being entered so the counter turns on the same edge.
  always_comb begin
    stop_hit            = stop && (phase_q != IDLE);
    phase_next          = stop_hit ? IDLE : norm_next;
    cnt.counter_state   = COUNT_DIS;
    cnt.counter_load    = '0;
    cnt.counter_load_en = 1'b0;
    if (!rst) begin
      if (stop_hit) begin
        cnt.counter_load    = CNT_W'(COUNTER_INIT);
        cnt.counter_load_en = 1'b1;
      end else begin
        cnt.counter_state = phase_dir(phase_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_next;
      done_q  <= (phase_q == DN3) && (phase_next == IDLE) && !stop_hit;
    end
  end

  assign busy  = !rst && (phase_q != IDLE);
  assign done  = !rst && done_q;
  assign phase = rst ? IDLE : phase_q;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl with a behavioural lamp counter model.
module tb_bound_flasher_ctrl;
  import bf_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   flick;
  logic   stop;
  logic   busy;
  logic   done;
  phase_t phase;
  logic [4:0] counter_q = 5'd0;
  int n_checks = 0;
  int n_fail = 0;

  bound_flasher_ctrl_if #(.CNT_W(5)) cnt_if ();

  bound_flasher_ctrl #(
    .CNT_W(5), .MAX_VAL(15), .MID_HI(10), .MID_LO(5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flick (flick),
    .stop  (stop),
    .cnt   (cnt_if.master),
    .busy  (busy),
    .done  (done),
    .phase (phase)
  );

  // clock / counter model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_if.counter_load_en) counter_q <= cnt_if.counter_load;
    else if (cnt_if.counter_state == COUNT_UP_EN) counter_q <= counter_q + 5'd1;
    else if (cnt_if.counter_state == COUNT_DOWN_EN) counter_q <= counter_q - 5'd1;
  end
  assign cnt_if.counter = counter_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    flick = 1'b1;
    tick();
    flick = 1'b0;
    #1;
  endtask

  task automatic run_to(input phase_t p, input logic [4:0] v, input int budget);
    int n;
    n = 0;
    while (!(phase == p && counter_q == v) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL run_to: phase %0d counter %0d, wanted phase %0d counter %0d", phase, counter_q, p, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flick = 1'b0; stop = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cnt_if.counter_state !== COUNT_DIS) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", cnt_if.counter_state, COUNT_DIS); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    n_checks++;
    if (cnt_if.counter_load_en !== 1'b0 || cnt_if.counter_load !== 5'd0) begin n_fail++; $display("FAIL reset_load: got %b/%0d expected 0/0", cnt_if.counter_load_en, cnt_if.counter_load); end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (counter_q !== 5'd0 || phase !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got counter %0d phase %0d busy %b expected 0 0 0", counter_q, phase, busy); end
  endtask

  task automatic test_full_run();
    int seq[51];
    int targets[6];
    int v;
    int idx;
    int bad;
    targets = '{15, 5, 10, 0, 5, 0};
    v = 0; idx = 0; seq[0] = 0;
    for (int t = 0; t < 6; t++) begin
      while (v != targets[t]) begin
        v = (targets[t] > v) ? v + 1 : v - 1;
        idx++;
        seq[idx] = v;
      end
    end
    flick = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_state !== COUNT_UP_EN) begin n_fail++; $display("FAIL start_dir: got %0d expected %0d", cnt_if.counter_state, COUNT_UP_EN); end
    tick();
    flick = 1'b0;
    #1;
    n_checks++;
    if (phase !== UP1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_phase: got phase %0d busy %b expected %0d 1", phase, busy, UP1); end
    bad = 0;
    for (int c = 1; c <= 50; c++) begin
      n_checks++;
      if (int'(counter_q) != seq[c] || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL run_cycle%0d: got counter %0d done %b busy %b expected %0d 0 1", c, counter_q, done, busy, seq[c]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || counter_q !== 5'd0) begin n_fail++; $display("FAIL done_pulse: got done %b busy %b counter %0d expected 1 0 0", done, busy, counter_q); end
    // flick held across the done cycle restarts straight away
    flick = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_state !== COUNT_UP_EN) begin n_fail++; $display("FAIL restart_dir: got %0d expected %0d", cnt_if.counter_state, COUNT_UP_EN); end
    tick();
    flick = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || counter_q !== 5'd1 || phase !== UP1) begin n_fail++; $display("FAIL restart: got done %b counter %0d phase %0d expected 0 1 %0d", done, counter_q, phase, UP1); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd0 || phase !== IDLE) begin n_fail++; $display("FAIL restart_abort: got counter %0d phase %0d expected 0 0", counter_q, phase); end
  endtask

  task automatic test_stop();
    start_run();
    run_to(DN1, 5'd12, 40);
    stop = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_load_en !== 1'b1 || cnt_if.counter_load !== 5'd0 || cnt_if.counter_state !== COUNT_DIS) begin
      n_fail++;
      $display("FAIL stop_cmd: got load_en %b load %0d state %0d expected 1 0 0", cnt_if.counter_load_en, cnt_if.counter_load, cnt_if.counter_state);
    end
    tick();
    stop = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd0 || phase !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_after: got counter %0d phase %0d busy %b done %b expected 0 0 0 0", counter_q, phase, busy, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL stop_no_done: got %b expected 0", done); end
  endtask

  task automatic test_kickback();
    start_run();
    run_to(DN2, 5'd5, 60);
    flick = 1'b1;
    tick();
    flick = 1'b0;
    #1;
`ifdef BF_KICKBACK_EN
    n_checks++;
    if (counter_q !== 5'd6 || phase !== UP2) begin n_fail++; $display("FAIL kick_mid: got counter %0d phase %0d expected 6 %0d", counter_q, phase, UP2); end
    run_to(DN2, 5'd9, 8);
    run_to(DN2, 5'd0, 15);
    flick = 1'b1;
    tick();
    flick = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd1 || phase !== UP2) begin n_fail++; $display("FAIL kick_zero: got counter %0d phase %0d expected 1 %0d", counter_q, phase, UP2); end
`else
    n_checks++;
    if (counter_q !== 5'd4 || phase !== DN2) begin n_fail++; $display("FAIL nokick_mid: got counter %0d phase %0d expected 4 %0d", counter_q, phase, DN2); end
    run_to(DN2, 5'd0, 8);
    flick = 1'b1;
    tick();
    flick = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd1 || phase !== UP3) begin n_fail++; $display("FAIL nokick_zero: got counter %0d phase %0d expected 1 %0d", counter_q, phase, UP3); end
`endif
    run_to(DN3, 5'd0, 80);
    tick();
    n_checks++;
    if (done !== 1'b1 || phase !== IDLE) begin n_fail++; $display("FAIL kick_done: got done %b phase %0d expected 1 0", done, phase); end
    tick();
  endtask

  task automatic test_priority();
    stop = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_load_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_stop: got load_en %b busy %b expected 0 0", cnt_if.counter_load_en, busy); end
    stop = 1'b0;
    start_run();
    run_to(DN2, 5'd5, 60);
    stop = 1'b1; flick = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_load_en !== 1'b1 || cnt_if.counter_state !== COUNT_DIS) begin n_fail++; $display("FAIL stop_over_kick: got load_en %b state %0d expected 1 0", cnt_if.counter_load_en, cnt_if.counter_state); end
    tick();
    stop = 1'b0; flick = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd0 || phase !== IDLE || done !== 1'b0) begin n_fail++; $display("FAIL stop_over_kick_after: got counter %0d phase %0d done %b expected 0 0 0", counter_q, phase, done); end
    start_run();
    run_to(UP3, 5'd2, 80);
    rst = 1'b1;
    #1;
    n_checks++;
    if (cnt_if.counter_state !== COUNT_DIS || cnt_if.counter_load_en !== 1'b0 || cnt_if.counter_load !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || phase !== IDLE) begin
      n_fail++;
      $display("FAIL rst_in_up3: got state %0d load_en %b load %0d busy %b done %b phase %0d expected all reset", cnt_if.counter_state, cnt_if.counter_load_en, cnt_if.counter_load, busy, done, phase);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (counter_q !== 5'd2 || phase !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after: got counter %0d phase %0d busy %b expected 2 0 0", counter_q, phase, busy); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stop();
    test_kickback();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bound_flasher_ctrl.md
Name: bound_flasher_ctrl

Overview:
- Sequencing controller for the bound flasher.
- Owns the phase FSM and drives the command side of the lamp counter interface: `counter_state`, `counter_load`, `counter_load_en`.
- Observes the registered lamp counter and the `flick` and `stop` inputs.
- Sits upstream of the next-counter generator, which turns these commands into the next counter value each cycle.

Parameters:
- CNT_W, 5, counter width.
- MAX_VAL, 15, top bound of first rise.
- MID_HI, 10, top bound of second rise.
- MID_LO, 5, turn-around / kickback point.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flick  in  1  start request; also the kickback request.
- stop  in  1  abort: return to IDLE and reload counter to 0.
- counter  in  CNT_W  current registered lamp count.
- counter_state  out  2  COUNT_DIS / COUNT_UP_EN / COUNT_DOWN_EN / COUNT_HOLD.
- counter_load  out  CNT_W  load value.
- counter_load_en  out  1  load strobe.
- busy  out  1  high when phase != IDLE.
- done  out  1  one-cycle pulse after sequence completes.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on `rst`.
- Reset values:
  - phase=IDLE
  - counter_state=COUNT_DIS
  - counter_load=0
  - counter_load_en=0
  - busy=0
  - done=0
- `rst` forces these outputs in the same cycle it is sampled high.
- Output timing:
  - Phase register updates on clk.
  - `counter_state` is combinational from phase_next, giving the direction of the phase being entered. The counter therefore turns on the same edge the phase changes, with no overshoot.
- Phases and direction:
  - IDLE: COUNT_DIS. flick=1 -> UP1.
  - UP1: up. counter>=MAX_VAL -> DN1.
  - DN1: down. counter<=MID_LO -> UP2.
  - UP2: up. counter>=MID_HI -> DN2.
  - DN2: down. counter==0 -> UP3.
  - UP3: up. counter>=MID_LO -> DN3.
  - DN3: down. counter==0 -> IDLE, and done=1 in the following cycle.
- Comparisons use >= / <= so an out-of-range counter still terminates the phase.
- flick:
  - Sampled only in IDLE, except for kickback.
  - flick held high in IDLE after done restarts immediately.
- stop:
  - In any non-IDLE phase, stop drives counter_load_en=1, counter_load=0, counter_state=COUNT_DIS. phase_next=IDLE.
  - No done pulse.
  - stop in IDLE is ignored.
- Priority: rst > stop > kickback > normal transition.
- Full sequence is 50 counter steps. The peak of 15 is held for exactly one cycle.
- COUNT_HOLD is never issued. It is reserved.

Optional Feature:
- Macro: BF_KICKBACK_EN.
- Defined:
  - In DN2, flick=1 while counter==MID_LO or counter==0 -> phase_next=UP2, counter_state=COUNT_UP_EN.
  - Repeats as often as flick recurs at those points.
- Undefined: flick is ignored outside IDLE, and DN2 always runs to 0.

Decomposition:
- Package `bf_pkg` holds:
  - counter_state enum: COUNT_DIS=2'b00, COUNT_UP_EN=2'b01, COUNT_DOWN_EN=2'b10, COUNT_HOLD=2'b11.
  - phase enum: IDLE, UP1, DN1, UP2, DN2, UP3, DN3.
  - COUNTER_INIT=0.
- The package is shared with the next-counter generator.
- One natural sub-module: `bf_phase_next`, the combinational phase_next/direction decode.
- Phase register, stop/load logic and done register stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with flick=0 -> counter_state=COUNT_DIS, busy=0, done=0, counter stays 0.
- Full run: one-cycle flick at counter=0 -> counter=1 next cycle. Counter then goes 15 -> 5 -> 10 -> 0 -> 5 -> 0. done pulses once, 51 cycles after the flick cycle. busy falls with done.
- Stop mid-run: stop=1 while in DN1 at counter=12 -> counter_load_en=1, counter_load=0 that cycle. Next cycle counter=0, phase=IDLE, done stays 0.
- Kickback (BF_KICKBACK_EN defined): flick=1 in DN2 at counter=5 -> counter=6 next cycle, phase=UP2, rises to 10 then falls again. Repeat with flick at counter=0 -> same result.
- Kickback disabled (macro undefined): same stimulus as above -> counter=4 next cycle, sequence unaffected.
- Priority: stop=1 and flick=1 together at counter=5 in DN2 -> load to 0 and IDLE, no kickback. rst=1 in UP3 -> all outputs at reset values that cycle.
